// File: rtl/cfa_diag_window_pkg.sv
// Shared defaults and FSM encoding for the CFA diagonal window.
// Imported by the window top.
package cfa_diag_window_pkg;

    localparam int DefDataBitWidth = 10;
    localparam int DefImgWidth     = 640;
    localparam int DefImgHeight    = 480;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/cfa_line_buffer.sv
// One raster line of packed G/RB pixels.
// Registered read; a read and write to the same address returns the old word.
module cfa_line_buffer #(
    parameter  int Width = 20,
    parameter  int Depth = 640,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;
    logic [Width-1:0] rdata_d;

    always_comb rdata_d = mem_q[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cfa_diag_window.sv
// Raster-order G/RB neighbourhood generator: emits the four diagonal
// neighbours of every interior centre pixel, one cycle after the accept.
module cfa_diag_window
    import cfa_diag_window_pkg::*;
#(
    parameter int DataBitWidth = DefDataBitWidth,
    parameter int ImgWidth     = DefImgWidth,
    parameter int ImgHeight    = DefImgHeight
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sof,
    input  logic                         pix_valid,
    input  logic [DataBitWidth-1:0]      g_in,
    input  logic [DataBitWidth-1:0]      rb_in,
    output logic [DataBitWidth-1:0]      G_m1_m1,
    output logic [DataBitWidth-1:0]      G_m1_p1,
    output logic [DataBitWidth-1:0]      G_p1_m1,
    output logic [DataBitWidth-1:0]      G_p1_p1,
    output logic [DataBitWidth-1:0]      RB_m1_m1,
    output logic [DataBitWidth-1:0]      RB_m1_p1,
    output logic [DataBitWidth-1:0]      RB_p1_m1,
    output logic [DataBitWidth-1:0]      RB_p1_p1,
    output logic                         out_valid,
    output logic [$clog2(ImgHeight)-1:0] out_row,
    output logic [$clog2(ImgWidth)-1:0]  out_col,
    output logic                         frame_done
);

    localparam int RW = $clog2(ImgHeight);
    localparam int CW = $clog2(ImgWidth);
    localparam int PW = 2 * DataBitWidth;
    localparam int DW = DataBitWidth;
    localparam logic [RW-1:0] LastRow = RW'(ImgHeight - 1);
    localparam logic [CW-1:0] LastCol = CW'(ImgWidth - 1);

    state_e state_q, state_d;

    logic [RW-1:0] row_q, row_d, cur_row;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic          restart, accept, last_pix, emit;

    logic [PW-1:0] pix, lb1_rdata, lb2_rdata;

    logic [1:0][PW-1:0] top_q, top_d;
    logic [1:0][PW-1:0] bot_q, bot_d;

    logic               out_valid_q, out_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [RW-1:0]      out_row_q, out_row_d;
    logic [CW-1:0]      out_col_q, out_col_d;
    logic [3:0][PW-1:0] diag_q, diag_d;

    assign pix      = {g_in, rb_in};
    assign restart  = pix_valid & sof;
    assign accept   = pix_valid & (sof | (state_q == RUN));
    assign cur_row  = restart ? '0 : row_q;
    assign cur_col  = restart ? '0 : col_q;
    assign last_pix = (cur_row == LastRow) && (cur_col == LastCol);
    assign emit     = accept && (cur_row > RW'(1)) && (cur_col > CW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (restart) state_d = RUN;
            RUN: begin
                if (accept && last_pix) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (cur_col == LastCol) begin
                col_d = '0;
                row_d = last_pix ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Reads look one pixel ahead so the registered word is ready at accept.
    cfa_line_buffer #(
        .Width (PW),
        .Depth (ImgWidth)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .waddr (cur_col),
        .wdata (pix),
        .raddr (col_d),
        .rdata (lb1_rdata)
    );

    cfa_line_buffer #(
        .Width (PW),
        .Depth (ImgWidth)
    ) u_lb2 (
        .clk   (clk),
        .we    (accept),
        .waddr (cur_col),
        .wdata (lb1_rdata),
        .raddr (col_d),
        .rdata (lb2_rdata)
    );

    always_comb begin
        top_d = top_q;
        bot_d = bot_q;
        if (accept) begin
            top_d = {top_q[0], lb2_rdata};
            bot_d = {bot_q[0], pix};
        end
    end

    always_ff @(posedge clk) begin
        top_q <= top_d;
        bot_q <= bot_d;
    end

    always_comb begin
        out_valid_d  = emit;
        frame_done_d = accept && last_pix;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        diag_d       = diag_q;
        if (emit) begin
            out_row_d = cur_row - RW'(1);
            out_col_d = cur_col - CW'(1);
            diag_d    = {pix, bot_q[1], lb2_rdata, top_q[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            diag_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            diag_q       <= diag_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

    assign G_m1_m1  = diag_q[0][PW-1 -: DW];
    assign G_m1_p1  = diag_q[1][PW-1 -: DW];
    assign G_p1_m1  = diag_q[2][PW-1 -: DW];
    assign G_p1_p1  = diag_q[3][PW-1 -: DW];
    assign RB_m1_m1 = diag_q[0][DW-1:0];
    assign RB_m1_p1 = diag_q[1][DW-1:0];
    assign RB_p1_m1 = diag_q[2][DW-1:0];
    assign RB_p1_p1 = diag_q[3][DW-1:0];

endmodule

// File: tb/tb_cfa_diag_window.sv
// Bench for cfa_diag_window: a 4x4 and a 5x3 instance share one pixel
// stream and are compared against a frame-image reference model.
module tb_cfa_diag_window;

    logic       clk;
    logic       rst, sof, pix_valid;
    logic [9:0] g_in, rb_in;

    logic       va, da, vb, db;
    logic [1:0] rowa, cola, rowb;
    logic [2:0] colb;
    logic [9:0] ga [4];
    logic [9:0] ra [4];
    logic [9:0] gb [4];
    logic [9:0] rbb [4];

    cfa_diag_window #(.DataBitWidth(10), .ImgWidth(4), .ImgHeight(4)) dut_a (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid),
        .g_in(g_in), .rb_in(rb_in),
        .G_m1_m1(ga[0]), .G_m1_p1(ga[1]), .G_p1_m1(ga[2]), .G_p1_p1(ga[3]),
        .RB_m1_m1(ra[0]), .RB_m1_p1(ra[1]), .RB_p1_m1(ra[2]), .RB_p1_p1(ra[3]),
        .out_valid(va), .out_row(rowa), .out_col(cola), .frame_done(da)
    );

    cfa_diag_window #(.DataBitWidth(10), .ImgWidth(5), .ImgHeight(3)) dut_b (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid),
        .g_in(g_in), .rb_in(rb_in),
        .G_m1_m1(gb[0]), .G_m1_p1(gb[1]), .G_p1_m1(gb[2]), .G_p1_p1(gb[3]),
        .RB_m1_m1(rbb[0]), .RB_m1_p1(rbb[1]), .RB_p1_m1(rbb[2]), .RB_p1_p1(rbb[3]),
        .out_valid(vb), .out_row(rowb), .out_col(colb), .frame_done(db)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: the frame as an image, indexed by raster position.
    int   mw [2] = '{4, 5};
    int   mh [2] = '{4, 3};
    logic m_act [2];
    int   m_r [2], m_c [2];
    int   img_g [2][8][8];
    int   img_rb [2][8][8];
    logic e_valid [2], e_done [2];
    int   e_row [2], e_col [2];
    int   e_g [2][4], e_rb [2][4];
    logic [97:0] expv [2];
    logic [97:0] obs [2];

    assign obs[0] = {va, da, 8'(rowa), 8'(cola), ga[0], ga[1], ga[2], ga[3],
                     ra[0], ra[1], ra[2], ra[3]};
    assign obs[1] = {vb, db, 8'(rowb), 8'(colb), gb[0], gb[1], gb[2], gb[3],
                     rbb[0], rbb[1], rbb[2], rbb[3]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic s, input logic v, input int g, input int rb);
        int r, c;
        sof = s;
        pix_valid = v;
        g_in = 10'(g);
        rb_in = 10'(rb);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_act[d] = 1'b0; m_r[d] = 0; m_c[d] = 0;
                e_valid[d] = 1'b0; e_done[d] = 1'b0; e_row[d] = 0; e_col[d] = 0;
                for (int k = 0; k < 4; k++) begin
                    e_g[d][k] = 0;
                    e_rb[d][k] = 0;
                end
            end else begin
                e_valid[d] = 1'b0;
                e_done[d] = 1'b0;
                if (v && (s || m_act[d])) begin
                    r = s ? 0 : m_r[d];
                    c = s ? 0 : m_c[d];
                    img_g[d][r][c] = g & 1023;
                    img_rb[d][r][c] = rb & 1023;
                    if (r >= 2 && c >= 2) begin
                        e_valid[d] = 1'b1;
                        e_row[d] = r - 1;
                        e_col[d] = c - 1;
                        e_g[d][0] = img_g[d][r-2][c-2]; e_rb[d][0] = img_rb[d][r-2][c-2];
                        e_g[d][1] = img_g[d][r-2][c];   e_rb[d][1] = img_rb[d][r-2][c];
                        e_g[d][2] = img_g[d][r][c-2];   e_rb[d][2] = img_rb[d][r][c-2];
                        e_g[d][3] = img_g[d][r][c];     e_rb[d][3] = img_rb[d][r][c];
                    end
                    if (r == mh[d] - 1 && c == mw[d] - 1) begin
                        m_act[d] = 1'b0; e_done[d] = 1'b1; m_r[d] = 0; m_c[d] = 0;
                    end else begin
                        m_act[d] = 1'b1;
                        c++;
                        if (c == mw[d]) begin
                            c = 0;
                            r++;
                        end
                        m_r[d] = r;
                        m_c[d] = c;
                    end
                end
            end
            expv[d] = {e_valid[d], e_done[d], 8'(e_row[d]), 8'(e_col[d]),
                       10'(e_g[d][0]), 10'(e_g[d][1]), 10'(e_g[d][2]), 10'(e_g[d][3]),
                       10'(e_rb[d][0]), 10'(e_rb[d][1]), 10'(e_rb[d][2]), 10'(e_rb[d][3])};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 5, 5);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs[d] !== expv[d]) begin
                n_fail++;
                $display("FAIL reset dut%0d got %h exp %h", d, obs[d], expv[d]);
            end
        end
        n_chk++;
        if (obs[0] !== '0 || obs[1] !== '0) begin
            n_fail++;
            $display("FAIL reset_zero got %h / %h exp 0", obs[0], obs[1]);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int np, nd;
        int er [4] = '{1, 1, 2, 2};
        int ec [4] = '{1, 2, 1, 2};
        np = 0;
        nd = 0;
        for (int p = 0; p < 17; p++) begin
            if (p < 16) drive(p == 0, 1'b1, 16*(p/4) + p%4, 200 + 16*(p/4) + p%4);
            else drive(1'b0, 1'b0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL basic dut%0d p=%0d got %h exp %h", d, p, obs[d], expv[d]);
                end
            end
            if (va) begin
                if (np == 0) begin
                    n_chk++;
                    if (ga[0] !== 10'd0 || ga[1] !== 10'd2 || ga[2] !== 10'd32 ||
                        ga[3] !== 10'd34 || ra[0] !== 10'd200 || ra[1] !== 10'd202 ||
                        ra[2] !== 10'd232 || ra[3] !== 10'd234) begin
                        n_fail++;
                        $display("FAIL basic_first got G %0d %0d %0d %0d RB %0d %0d %0d %0d",
                                 ga[0], ga[1], ga[2], ga[3], ra[0], ra[1], ra[2], ra[3]);
                    end
                end
                if (np < 4) begin
                    n_chk++;
                    if (int'(rowa) != er[np] || int'(cola) != ec[np]) begin
                        n_fail++;
                        $display("FAIL basic_centre got (%0d,%0d) exp (%0d,%0d)",
                                 rowa, cola, er[np], ec[np]);
                    end
                end
                np++;
            end
            if (da) begin
                nd++;
                n_chk++;
                if (p != 15) begin
                    n_fail++;
                    $display("FAIL basic_done_time got p=%0d exp p=15", p);
                end
            end
        end
        n_chk++;
        if (np != 4 || nd != 1) begin
            n_fail++;
            $display("FAIL basic_count got %0d pulses %0d done exp 4 1", np, nd);
        end
    endtask

    task automatic test_gaps();
        int p, np, cyc;
        p = 0;
        np = 0;
        cyc = 0;
        while (p < 16 && cyc < 400) begin
            if ($urandom_range(1, 0) == 1) begin
                drive(p == 0, 1'b1, 16*(p/4) + p%4, 200 + 16*(p/4) + p%4);
                p++;
            end else begin
                drive(1'($urandom_range(1, 0)), 1'b0,
                      int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)));
            end
            cyc++;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL gaps dut%0d cyc=%0d got %h exp %h", d, cyc, obs[d], expv[d]);
                end
            end
            if (va) np++;
        end
        n_chk++;
        if (p != 16 || np != 4) begin
            n_fail++;
            $display("FAIL gaps_count got %0d px %0d pulses exp 16 4", p, np);
        end
    endtask

    task automatic test_wrap();
        int np;
        int ec [3] = '{1, 2, 3};
        np = 0;
        for (int p = 0; p < 16; p++) begin
            if (p < 15) drive(p == 0, 1'b1, 16*(p/5) + p%5, 200 + 16*(p/5) + p%5);
            else drive(1'b0, 1'b0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL wrap dut%0d p=%0d got %h exp %h", d, p, obs[d], expv[d]);
                end
            end
            if (p == 10 || p == 11) begin
                n_chk++;
                if (vb !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_early p=%0d got out_valid %b exp 0", p, vb);
                end
            end
            if (vb) begin
                if (np < 3) begin
                    n_chk++;
                    if (int'(rowb) != 1 || int'(colb) != ec[np]) begin
                        n_fail++;
                        $display("FAIL wrap_centre got (%0d,%0d) exp (1,%0d)", rowb, colb, ec[np]);
                    end
                end
                if (int'(colb) == 1) begin
                    n_chk++;
                    if (rbb[0] !== 10'd200) begin
                        n_fail++;
                        $display("FAIL wrap_rb_mm got %0d exp 200", rbb[0]);
                    end
                end
                np++;
            end
        end
        n_chk++;
        if (np != 3) begin
            n_fail++;
            $display("FAIL wrap_count got %0d exp 3", np);
        end
    endtask

    task automatic test_restart();
        int np;
        np = 0;
        for (int p = 0; p < 9; p++) begin
            drive(p == 0, 1'b1, 300 + 16*(p/4) + p%4, 600 + 16*(p/4) + p%4);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL restart_a dut%0d p=%0d got %h exp %h", d, p, obs[d], expv[d]);
                end
            end
        end
        for (int p = 0; p < 17; p++) begin
            if (p < 16) drive(p == 0, 1'b1, 16*(p/4) + p%4, 200 + 16*(p/4) + p%4);
            else drive(1'b0, 1'b0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL restart_b dut%0d p=%0d got %h exp %h", d, p, obs[d], expv[d]);
                end
            end
            if (va) begin
                n_chk++;
                if (p < 10 || (np == 0 && (ga[0] !== 10'd0 || ra[3] !== 10'd234))) begin
                    n_fail++;
                    $display("FAIL restart_pulse p=%0d got G %0d RB %0d exp p>=10 G 0 RB 234",
                             p, ga[0], ra[3]);
                end
                np++;
            end
        end
        n_chk++;
        if (np != 4) begin
            n_fail++;
            $display("FAIL restart_count got %0d exp 4", np);
        end
    endtask

    task automatic test_reset_mid();
        int np;
        np = 0;
        for (int p = 0; p < 9; p++) begin
            drive(p == 0, 1'b1, 16*(p/4) + p%4, 200 + 16*(p/4) + p%4);
        end
        rst = 1'b0;
        drive(1'b0, 1'b1, 33, 233);
        rst = 1'b1;
        n_chk++;
        if (obs[0] !== '0 || obs[1] !== '0) begin
            n_fail++;
            $display("FAIL rstmid_zero got %h / %h exp 0", obs[0], obs[1]);
        end
        for (int p = 0; p < 3; p++) begin
            drive(1'b0, 1'b1, 40 + p, 240 + p);
            n_chk++;
            if (va !== 1'b0 || da !== 1'b0 || obs[0] !== expv[0]) begin
                n_fail++;
                $display("FAIL rstmid_idle got %h exp %h", obs[0], expv[0]);
            end
        end
        for (int p = 0; p < 17; p++) begin
            if (p < 16) drive(p == 0, 1'b1, 16*(p/4) + p%4, 200 + 16*(p/4) + p%4);
            else drive(1'b0, 1'b0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL rstmid dut%0d p=%0d got %h exp %h", d, p, obs[d], expv[d]);
                end
            end
            if (va) begin
                if (np == 0) begin
                    n_chk++;
                    if (ga[1] !== 10'd2 || ga[2] !== 10'd32 || ra[0] !== 10'd200) begin
                        n_fail++;
                        $display("FAIL rstmid_first got %0d %0d %0d exp 2 32 200",
                                 ga[1], ga[2], ra[0]);
                    end
                end
                np++;
            end
        end
        n_chk++;
        if (np != 4) begin
            n_fail++;
            $display("FAIL rstmid_count got %0d exp 4", np);
        end
    endtask

    task automatic test_back_to_back();
        int np2, nd, q, f;
        np2 = 0;
        nd = 0;
        for (int p = 0; p < 33; p++) begin
            f = p / 16;
            q = p % 16;
            if (p < 32) drive(q == 0, 1'b1, 100*f + 16*(q/4) + q%4, 200 + 100*f + 16*(q/4) + q%4);
            else drive(1'b0, 1'b0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL b2b dut%0d p=%0d got %h exp %h", d, p, obs[d], expv[d]);
                end
            end
            if (da) begin
                nd++;
                n_chk++;
                if (p != 15 && p != 31) begin
                    n_fail++;
                    $display("FAIL b2b_done_time got p=%0d exp 15 or 31", p);
                end
            end
            if (va && p >= 16) np2++;
        end
        n_chk++;
        if (np2 != 4 || nd != 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d pulses %0d done exp 4 2", np2, nd);
        end
    endtask

    initial begin
        rst = 1'b0;
        sof = 1'b0;
        pix_valid = 1'b0;
        g_in = '0;
        rb_in = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_wrap();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
